// File: rtl/mem_stage.sv
// mem_stage: RV32I load/store unit; turns EX/MEM slots into req/ack bus transactions
// and drives the MEM/WB register, stalling the pipeline while a transaction is open.
module mem_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        rd_write_enable,
    input  logic [4:0]  rd_write_addr,
    input  logic [1:0]  res_src,
    input  logic        mem_write_enable,
    input  logic [2:0]  mem_width_in,
    input  logic [31:0] exec_out,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] next_pc_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        rd_write_enable_out,
    output logic [4:0]  rd_write_addr_out,
    output logic [1:0]  res_src_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] load_data_out,
    output logic [31:0] next_pc_out,
    output logic        valid_out,
    output logic        mem_fault_out
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_s_rd_we;
    logic [4:0]  r_s_rd_addr;
    logic [1:0]  r_s_res_src;
    logic [2:0]  r_s_width;
    logic [1:0]  r_s_lo;
    logic [31:0] r_s_alu;
    logic [31:0] r_s_npc;
    logic [31:0] r_rdata;
    logic        r_to;
    logic        w_is_load, w_is_store, w_mem_op, w_bad_width, w_misal, w_fault, w_go, w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_sh, w_ld;
    always_comb begin
        w_is_load   = valid_in && (res_src == 2'b01);
        w_is_store  = valid_in && mem_write_enable;
        w_mem_op    = w_is_load || w_is_store;
        w_bad_width = (mem_width_in == 3'b011) || (mem_width_in == 3'b110) || (mem_width_in == 3'b111);
        w_misal     = ((mem_width_in[1:0] == 2'b10) && (exec_out[1:0] != 2'b00)) ||
                      ((mem_width_in[1:0] == 2'b01) && exec_out[0]);
        w_fault     = w_mem_op && (w_bad_width || w_misal);
        w_go        = (r_state == IDLE) && w_mem_op && !w_fault;
        w_timeout   = (BUS_TIMEOUT != 0) && (r_state == BUSY) && !dmem_ack &&
                      (r_cnt == 32'(BUS_TIMEOUT - 1));
        w_next      = (r_state == IDLE) ? (w_go ? BUSY : IDLE) :
                      (r_state == BUSY) ? ((dmem_ack || w_timeout) ? RESP : BUSY) : IDLE;
        w_wstrb     = (mem_width_in[1:0] == 2'b00) ? 4'b0001 << exec_out[1:0] :
                      (mem_width_in[1:0] == 2'b01) ? (exec_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata     = (mem_width_in[1:0] == 2'b00) ? {4{mem_write_data[7:0]}} :
                      (mem_width_in[1:0] == 2'b01) ? {2{mem_write_data[15:0]}} : mem_write_data;
        // Load formatting works on the captured word and the slot copied at issue.
        w_sh        = r_rdata >> {r_s_lo, 3'b000};
        w_ld        = (r_s_width == 3'b000) ? {{24{w_sh[7]}}, w_sh[7:0]} :
                      (r_s_width == 3'b001) ? {{16{w_sh[15]}}, w_sh[15:0]} :
                      (r_s_width == 3'b100) ? {24'b0, w_sh[7:0]} :
                      (r_s_width == 3'b101) ? {16'b0, w_sh[15:0]} : r_rdata;
        stall_out   = w_go || (r_state == BUSY);
        dmem_req    = (r_state == BUSY);
        dmem_we     = r_we;
        dmem_addr   = r_addr;
        dmem_wstrb  = r_wstrb;
        dmem_wdata  = r_wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= IDLE;
            r_cnt               <= '0;
            r_we                <= 1'b0;
            r_addr              <= '0;
            r_wstrb             <= '0;
            r_wdata             <= '0;
            r_s_rd_we           <= 1'b0;
            r_s_rd_addr         <= '0;
            r_s_res_src         <= '0;
            r_s_width           <= '0;
            r_s_lo              <= '0;
            r_s_alu             <= '0;
            r_s_npc             <= '0;
            r_rdata             <= '0;
            r_to                <= 1'b0;
            rd_write_enable_out <= 1'b0;
            rd_write_addr_out   <= '0;
            res_src_out         <= '0;
            alu_result_out      <= '0;
            load_data_out       <= '0;
            next_pc_out         <= '0;
            valid_out           <= 1'b0;
            mem_fault_out       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                // Non-mem and faulting slots retire here; a good mem_op leaves a bubble.
                valid_out           <= valid_in && !w_go;
                rd_write_enable_out <= valid_in && rd_write_enable && !w_mem_op;
                mem_fault_out       <= w_fault;
                rd_write_addr_out   <= rd_write_addr;
                res_src_out         <= res_src;
                alu_result_out      <= exec_out;
                next_pc_out         <= next_pc_in;
                load_data_out       <= '0;
                if (w_go) begin
                    r_cnt       <= '0;
                    r_we        <= w_is_store;
                    r_addr      <= {exec_out[31:2], 2'b00};
                    r_wstrb     <= w_is_store ? w_wstrb : 4'b0000;
                    r_wdata     <= w_is_store ? w_wdata : 32'b0;
                    r_s_rd_we   <= rd_write_enable;
                    r_s_rd_addr <= rd_write_addr;
                    r_s_res_src <= res_src;
                    r_s_width   <= mem_width_in;
                    r_s_lo      <= exec_out[1:0];
                    r_s_alu     <= exec_out;
                    r_s_npc     <= next_pc_in;
                    r_rdata     <= '0;
                    r_to        <= 1'b0;
                end
            end else if (r_state == BUSY) begin
                valid_out           <= 1'b0;
                rd_write_enable_out <= 1'b0;
                mem_fault_out       <= 1'b0;
                r_to                <= w_timeout;
                if (dmem_ack) r_rdata <= dmem_rdata;
                else r_cnt <= r_cnt + 32'd1;
            end else begin
                valid_out           <= 1'b1;
                rd_write_enable_out <= r_s_rd_we && !r_to;
                mem_fault_out       <= r_to;
                rd_write_addr_out   <= r_s_rd_addr;
                res_src_out         <= r_s_res_src;
                alu_result_out      <= r_s_alu;
                next_pc_out         <= r_s_npc;
                load_data_out       <= r_to ? 32'b0 : w_ld;
            end
        end
    end
endmodule
